// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: controller states
// and the address-split width helpers.
package icache_dm_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_LOOKUP    = 3'd2,
    ST_MISS_REQ  = 3'd3,
    ST_MISS_WAIT = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  function automatic int offset_bits(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_w, input int block_words, input int lines);
    return addr_w - $clog2(block_words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Cache bus: fetch request/response and flush on one side, block refill on the other.
// The slave modport is the cache itself; master is the fetch stage plus memory.
interface icache_dm_if #(
  parameter int ADDR_W      = 16,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  logic                          req_valid;
  logic                          req_ready;
  logic [ADDR_W-1:0]             req_addr;
  logic                          resp_valid;
  logic [WORD_W-1:0]             resp_data;
  logic                          flush;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [ADDR_W-1:0]             mem_req_addr;
  logic                          mem_resp_valid;
  logic [BLOCK_WORDS*WORD_W-1:0] mem_resp_data;

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_tag_array.sv
// Valid+tag storage with a combinational hit compare, a single-line fill port
// and a per-index valid clear driven by the flush sequencer.
module icache_tag_array #(
  parameter int LINES = 4,
  parameter int IW    = 2,
  parameter int TW    = 12
) (
  input  logic          clk,
  input  logic [IW-1:0] index,
  input  logic [TW-1:0] tag,
  output logic          hit,
  input  logic          wr_en,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_index
);
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];

  assign hit = valid[index] && (tags[index] == tag);

  always_ff @(posedge clk) begin
    if (clr_en) valid[clr_index] <= 1'b0;
    if (wr_en) begin
      valid[index] <= 1'b1;
      tags[index]  <= tag;
    end
  end
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 1-cycle hits, single-beat block refill on a miss,
// sequenced invalidate-all and saturating hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int LINES       = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  icache_dm_if.slave       bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int OB = offset_bits(BLOCK_WORDS);
  localparam int IW = index_bits(LINES);
  localparam int TW = tag_bits(ADDR_W, BLOCK_WORDS, LINES);

  state_e            state, state_nxt;
  logic [IW-1:0]     flush_idx;
  logic              flush_pend;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              hit, accept, refill, clr_en, pend_window;

  logic [BLOCK_WORDS-1:0][WORD_W-1:0] data_mem [LINES];

  logic [OB-1:0] cur_off;
  logic [IW-1:0] cur_idx;
  logic [TW-1:0] cur_tag;

  assign cur_off = addr_q[OB-1:0];
  assign cur_idx = addr_q[OB+IW-1:OB];
  assign cur_tag = addr_q[ADDR_W-1:OB+IW];
  assign bus.mem_req_addr = mem_addr_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  icache_tag_array #(.LINES(LINES), .IW(IW), .TW(TW)) u_tags (
    .clk       (clk),
    .index     (cur_idx),
    .tag       (cur_tag),
    .hit       (hit),
    .wr_en     (refill),
    .clr_en    (clr_en),
    .clr_index (flush_idx)
  );

  // A flush seen while a miss is in flight is deferred until the response is out.
  assign pend_window = (state == ST_MISS_REQ) || (state == ST_MISS_WAIT) ||
                       ((state == ST_LOOKUP) && !hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FLUSH;
      flush_idx  <= '0;
      flush_pend <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      mem_addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FLUSH) flush_idx <= flush_idx + IW'(1);
      if (state == ST_FLUSH)             flush_pend <= 1'b0;
      else if (bus.flush && pend_window) flush_pend <= 1'b1;
      if (state == ST_LOOKUP) begin
        if (hit) begin
          hit_count <= sat_inc(hit_count);
        end else begin
          miss_count <= sat_inc(miss_count);
          mem_addr_q <= {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= bus.req_addr;
    if (refill) data_mem[cur_idx] <= bus.mem_resp_data;
  end

  always_comb begin
    state_nxt         = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_data     = '0;
    bus.mem_req_valid = 1'b0;
    accept            = 1'b0;
    refill            = 1'b0;
    clr_en            = 1'b0;
    case (state)
      ST_FLUSH: begin
        clr_en = 1'b1;
        if (flush_idx == IW'(LINES - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        bus.req_ready = !bus.flush;
        accept        = bus.req_valid && !bus.flush;
        if (bus.flush)      state_nxt = ST_FLUSH;
        else if (accept)    state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_data  = data_mem[cur_idx][cur_off];
          bus.req_ready  = !bus.flush;
          accept         = bus.req_valid && !bus.flush;
          if (bus.flush)   state_nxt = ST_FLUSH;
          else if (accept) state_nxt = ST_LOOKUP;
          else             state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        refill = bus.mem_resp_valid;
        if (bus.mem_resp_valid) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = data_mem[cur_idx][cur_off];
        state_nxt      = (flush_pend || bus.flush) ? ST_FLUSH : ST_IDLE;
      end
      default: state_nxt = ST_FLUSH;
    endcase
  end
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus random fetches against a
// line/tag reference model; memory returns word k = 0xA000_0000 + block_addr + k.
module tb_icache_dm;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int BW      = 4;
  localparam int LINES   = 4;
  localparam int CNT_W   = 32;
  localparam int BLOCK_W = BW * WORD_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] hit_count, miss_count;

  int checks   = 0;
  int failures = 0;

  bit m_valid [LINES];
  int m_tag   [LINES];
  int m_hits  = 0;
  int m_miss  = 0;

  icache_dm_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW)) bus ();

  icache_dm #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .BLOCK_WORDS(BW), .LINES(LINES), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] word_of(input int a);
    return WORD_W'(32'hA000_0000 + a);
  endfunction

  function automatic logic [BLOCK_W-1:0] block_of(input int baddr);
    logic [BLOCK_W-1:0] b;
    for (int k = 0; k < BW; k++) b[k*WORD_W +: WORD_W] = word_of(baddr + k);
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Returns 1 on a hit; a miss installs the block's tag.
  function automatic bit model_access(input int a);
    int l, t;
    l = (a / BW) % LINES;
    t = a / (BW * LINES);
    if (m_valid[l] && m_tag[l] == t) begin
      m_hits++;
      return 1'b1;
    end
    m_valid[l] = 1'b1;
    m_tag[l]   = t;
    m_miss++;
    return 1'b0;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL %s_ready_timeout: req_ready=%0b required=1", name, bus.req_ready);
    end
    checks++;
  endtask

  task automatic serve_mem(input int baddr, input int stall, input int delay);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!bus.mem_req_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (bus.mem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL mem_req_timeout: mem_req_valid=%0b required=1", bus.mem_req_valid);
    end
    checks++;
    if (bus.mem_req_addr !== ADDR_W'(baddr)) begin
      failures++;
      $display("FAIL mem_req_addr: got=%h required=%h", bus.mem_req_addr, ADDR_W'(baddr));
    end
    checks++;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      bus.mem_resp_valid = (i == 0);
      bus.mem_resp_data  = ~block_of(baddr);
      #1;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== ADDR_W'(baddr)) begin
        failures++;
        $display("FAIL mem_req_hold: valid=%0b addr=%h required valid=1 addr=%h",
                 bus.mem_req_valid, bus.mem_req_addr, ADDR_W'(baddr));
      end
      checks++;
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b1;
    #1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    if (bus.mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mem_req_drop: mem_req_valid=%0b required=0", bus.mem_req_valid);
    end
    checks++;
    repeat (delay) @(negedge clk);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = block_of(baddr);
    #1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    #1;
  endtask

  task automatic fetch_one(input int a, input int stall, input int delay);
    bit exp_hit;
    exp_hit = model_access(a);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDR_W'(a);
    #1;
    wait_ready("fetch");
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    if (bus.resp_valid !== exp_hit) begin
      failures++;
      $display("FAIL lookup_hit addr=%h: resp_valid=%0b required=%0b", a, bus.resp_valid, exp_hit);
    end
    checks++;
    if (exp_hit) begin
      if (bus.resp_data !== word_of(a)) begin
        failures++;
        $display("FAIL hit_data addr=%h: got=%h required=%h", a, bus.resp_data, word_of(a));
      end
      checks++;
    end else begin
      serve_mem(a - (a % BW), stall, delay);
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== word_of(a)) begin
        failures++;
        $display("FAIL refill_resp addr=%h: valid=%0b data=%h required valid=1 data=%h",
                 a, bus.resp_valid, bus.resp_data, word_of(a));
      end
      checks++;
    end
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (hit_count !== '0 || miss_count !== '0) begin
      failures++;
      $display("FAIL reset_counters: hit=%0d miss=%0d required 0 0", hit_count, miss_count);
    end
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.mem_req_addr !== '0 || bus.resp_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: mem_req_valid=%0b resp_valid=%0b mem_req_addr=%h resp_data=%h required all 0",
               bus.mem_req_valid, bus.resp_valid, bus.mem_req_addr, bus.resp_data);
    end
    checks++;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    if (n != 4) begin
      failures++;
      $display("FAIL reset_flush_len: not-ready cycles=%0d required=4", n);
    end
    checks++;
    model_clear();
  endtask

  task automatic test_cold_miss();
    fetch_one(16'h0005, 0, 3);
    @(negedge clk); #1;
    if (bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL cold_single_pulse: resp_valid=%0b required=0", bus.resp_valid);
    end
    checks++;
    if (miss_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL cold_miss_count: got=%0d required=1", miss_count);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    bit e6, e7;
    e6 = model_access(16'h0006);
    e7 = model_access(16'h0007);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0006;
    #1;
    wait_ready("b2b");
    @(negedge clk);
    bus.req_addr = 16'h0007;
    #1;
    if (bus.resp_valid !== e6 || bus.resp_data !== word_of(6) || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: valid=%0b data=%h ready=%0b required valid=%0b data=%h ready=1",
               bus.resp_valid, bus.resp_data, bus.req_ready, e6, word_of(6));
    end
    checks++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    if (bus.resp_valid !== e7 || bus.resp_data !== word_of(7)) begin
      failures++;
      $display("FAIL b2b_second: valid=%0b data=%h required valid=%0b data=%h",
               bus.resp_valid, bus.resp_data, e7, word_of(7));
    end
    checks++;
    @(negedge clk); #1;
    if (bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: resp_valid=%0b required=0", bus.resp_valid);
    end
    checks++;
    if (hit_count !== CNT_W'(m_hits)) begin
      failures++;
      $display("FAIL b2b_hit_count: got=%0d required=%0d", hit_count, m_hits);
    end
    checks++;
  endtask

  task automatic test_conflict();
    fetch_one(16'h0014, 0, 1);
    fetch_one(16'h0005, 2, 2);
    if (miss_count !== CNT_W'(m_miss)) begin
      failures++;
      $display("FAIL conflict_miss_count: got=%0d required=%0d", miss_count, m_miss);
    end
    checks++;
  endtask

  task automatic test_flush_wait();
    int  n;
    bit  e;
    e = model_access(16'h0008);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0008;
    #1;
    wait_ready("flushw");
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    if (bus.resp_valid !== e) begin
      failures++;
      $display("FAIL flushw_lookup: resp_valid=%0b required=%0b", bus.resp_valid, e);
    end
    checks++;
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 16'h0008) begin
      failures++;
      $display("FAIL flushw_memreq: valid=%0b addr=%h required valid=1 addr=0008",
               bus.mem_req_valid, bus.mem_req_addr);
    end
    checks++;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.flush         = 1'b1;
    #1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = block_of(16'h0008);
    #1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== word_of(8)) begin
      failures++;
      $display("FAIL flushw_resp: valid=%0b data=%h required valid=1 data=%h",
               bus.resp_valid, bus.resp_data, word_of(8));
    end
    checks++;
    n = 0;
    @(negedge clk); #1;
    while (!bus.req_ready && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    if (n != 4) begin
      failures++;
      $display("FAIL flushw_flush_len: not-ready cycles=%0d required=4", n);
    end
    checks++;
    model_clear();
    fetch_one(16'h0005, 0, 0);
  endtask

  task automatic test_stall_reset();
    bit e;
    e = model_access(16'h0030);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0030;
    #1;
    wait_ready("stall");
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    if (bus.resp_valid !== e) begin
      failures++;
      $display("FAIL stall_lookup: resp_valid=%0b required=%0b", bus.resp_valid, e);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 16'h0030) begin
        failures++;
        $display("FAIL stall_hold cycle %0d: valid=%0b addr=%h required valid=1 addr=0030",
                 i, bus.mem_req_valid, bus.mem_req_addr);
      end
      checks++;
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst               = 1'b1;
    #1;
    @(negedge clk);
    rst                = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = block_of(16'h0030);
    #1;
    if (bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_reset_outputs: resp_valid=%0b mem_req_valid=%0b required 0 0",
               bus.resp_valid, bus.mem_req_valid);
    end
    checks++;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    if (bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_late_data: resp_valid=%0b required=0", bus.resp_valid);
    end
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      failures++;
      $display("FAIL stall_reset_counters: hit=%0d miss=%0d required 0 0", hit_count, miss_count);
    end
    checks++;
    model_clear();
    m_hits = 0;
    m_miss = 0;
    wait_ready("stall_flush");
    fetch_one(16'h0030, 0, 0);
    fetch_one(16'h0005, 0, 1);
    fetch_one(16'h0014, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        model_clear();
      end
      fetch_one(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    if (hit_count !== CNT_W'(m_hits) || miss_count !== CNT_W'(m_miss)) begin
      failures++;
      $display("FAIL random_counters: hit=%0d miss=%0d required hit=%0d miss=%0d",
               hit_count, miss_count, m_hits, m_miss);
    end
    checks++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush_wait();
    test_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache with a refill engine. It is the successor to the fixed single-block instruction cache. It sits between the fetch stage and the instruction memory:
- serves word fetches in 1 cycle on a hit;
- on a miss, fetches a whole block from instruction memory over a valid/ready handshake;
- supports a sequenced invalidate-all (flush) and hit/miss statistics.

Parameters:
WORD_W, 32, instruction word width in bits
ADDR_W, 16, word-address width (addresses are word indices, not bytes)
BLOCK_WORDS, 4, words per line; power of 2, >=2
LINES, 4, number of lines; power of 2, >=2
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request
req_ready  out  1  cache can accept a request this cycle
req_addr  in  ADDR_W  fetch word address
resp_valid  out  1  one-cycle pulse; resp_data valid
resp_data  out  WORD_W  fetched word
flush  in  1  request invalidate-all (level, sampled each cycle)
mem_req_valid  out  1  refill request to instruction memory
mem_req_ready  in  1  memory accepts refill request
mem_req_addr  out  ADDR_W  block-aligned refill address (offset bits zero)
mem_resp_valid  in  1  refill data valid (single beat)
mem_resp_data  in  BLOCK_WORDS*WORD_W  block data; word 0 in LSBs
hit_count  out  CNT_W  accepted requests that hit; saturating
miss_count  out  CNT_W  accepted requests that missed; saturating

Behaviour:
- Clocking: single clock clk; synchronous active-high reset rst.
- Address split: offset = addr[OB-1:0], OB = log2(BLOCK_WORDS); index = next log2(LINES) bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, data block.
- States: FLUSH, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
- Reset:
  - state <= FLUSH, flush index <= 0.
  - req_ready, resp_valid, mem_req_valid <= 0.
  - hit_count, miss_count <= 0.
  - resp_data and mem_req_addr reset to 0.
- FLUSH:
  - clears the valid bit of one line per cycle, index 0..LINES-1, so it lasts LINES cycles; then goes to IDLE.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches the address and goes to LOOKUP.
  - flush asserted in IDLE with no handshake goes to FLUSH.
  - flush has priority over a same-cycle request: req_ready=0 in that cycle.
- LOOKUP:
  - Hit (valid & tag match): resp_valid=1 with the selected word (latency: accept at cycle N, response at N+1); hit_count++.
  - Back-to-back: req_ready=1 in LOOKUP only when the current lookup hits and flush is low, so sequential hits sustain 1 word/cycle. A new handshake stays in LOOKUP; otherwise go to IDLE (or FLUSH if flush is high).
  - Miss: miss_count++, go to MISS_REQ, req_ready=0.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = {tag,index,0}, both held stable until mem_req_ready.
  - Handshake goes to MISS_WAIT; mem_req_valid drops the following cycle.
- MISS_WAIT:
  - Waits indefinitely for mem_resp_valid.
  - On mem_resp_valid: writes the block, tag and valid bit, then goes to RESP.
  - mem_resp_valid outside MISS_WAIT is ignored.
- RESP:
  - resp_valid=1 with the requested word from the just-written block.
  - Goes to IDLE, or FLUSH if a flush is pending.
- Flush during MISS_REQ/MISS_WAIT/RESP:
  - latched into a pending flag;
  - the refill and response complete first, then FLUSH runs.
- Counters saturate at all-ones; no wrap.
- Reset mid-operation: abandons any refill; mem_req_valid=0 the next cycle; late memory data is ignored; all lines are invalid after the FLUSH sequence.

Decomposition:
- Shared define header: state encodings; derived widths (OB, index width, tag width); BLOCK_W = BLOCK_WORDS*WORD_W.
- One sub-module: icache_tag_array. It holds valid+tag storage and provides:
  - combinational hit compare;
  - single-line write;
  - per-index valid clear for the flush sequencer.
- Data array and FSM stay in icache_dm.

Test Plan:
Defaults throughout; memory block returns word k = 0xA000_0000 + block_addr + k.
- Reset: hold rst 2 cycles -> req_ready=0 for exactly 4 cycles after release, then 1; hit_count=miss_count=0.
- Cold miss: req 0x0005 -> mem_req_addr=0x0004; memory responds 3 cycles later -> resp_data=0xA000_0005, one resp_valid pulse; miss_count=1.
- Back-to-back hits: req 0x0006 then 0x0007 on consecutive cycles -> resp 0xA000_0006, 0xA000_0007 on consecutive cycles; hit_count=2.
- Conflict: req 0x0014 (index 1, tag 1) -> miss, mem_req_addr=0x0014; then req 0x0005 misses again; miss_count=3.
- Flush during MISS_WAIT, then refill returns -> response delivered, then 4 FLUSH cycles (req_ready=0), then req 0x0005 misses.
- Stall and reset: hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable. Then assert rst during MISS_WAIT with mem_resp_valid arriving one cycle later -> no resp_valid, mem_req_valid=0, all subsequent first accesses miss.
